// File: rtl/sram_param_pkg.sv
// Shared types and helpers for the parametrised 1RW+1R SRAM: FSM states,
// mask-lane count derivation and the byte-lane merge used by write and forwarding.
package sram_param_pkg;

  typedef enum logic {
    CLEAR,
    READY
  } sram_state_e;

  // Widest word the lane-merge helper handles; callers zero-extend into it.
  localparam int unsigned MAX_WIDTH = 256;
  localparam int unsigned IDX_W     = $clog2(MAX_WIDTH);

  function automatic int unsigned num_wmasks(input int unsigned data_width,
                                             input int unsigned write_size);
    return (write_size == 0) ? 0 : data_width / write_size;
  endfunction

  function automatic logic [MAX_WIDTH-1:0] lane_merge(
    input logic [MAX_WIDTH-1:0] old_word,
    input logic [MAX_WIDTH-1:0] new_word,
    input logic [MAX_WIDTH-1:0] mask,
    input int unsigned          lane_width
  );
    logic [MAX_WIDTH-1:0] merged;
    merged = old_word;
    if (lane_width != 0) begin
      for (int unsigned i = 0; i < MAX_WIDTH; i++) begin
        if (mask[IDX_W'(i / lane_width)]) merged[IDX_W'(i)] = new_word[IDX_W'(i)];
      end
    end
    return merged;
  endfunction

endpackage

// File: rtl/sky130_sram_param_1rw1r_clear_seq.sv
// Post-reset clear sequencer: sweeps every address once, then parks in READY.
module sram_clear_seq
  import sram_param_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = 8,
  parameter bit          INIT_EN    = 1'b1
) (
  input  logic                  clk,
  input  logic                  rstb,
  output logic                  clr_we,
  output logic [ADDR_WIDTH-1:0] clr_addr,
  output logic                  init_done
);

  sram_state_e           state, state_next;
  logic [ADDR_WIDTH-1:0] cnt, cnt_next;

  // init_done is registered so it trails READY by one cycle and is 0 out of reset.
  always_ff @(posedge clk) begin
    if (!rstb) begin
      state     <= INIT_EN ? CLEAR : READY;
      cnt       <= '0;
      init_done <= 1'b0;
    end else begin
      state     <= state_next;
      cnt       <= cnt_next;
      init_done <= (state == READY);
    end
  end

  always_comb begin
    state_next = state;
    cnt_next   = cnt;
    clr_we     = 1'b0;
    case (state)
      CLEAR: begin
        clr_we   = 1'b1;
        cnt_next = cnt + 1'b1;
        if (cnt == '1) state_next = READY;
      end
      READY: begin
        state_next = READY;
      end
    endcase
  end

  assign clr_addr = cnt;

endmodule

// File: rtl/sky130_sram_param_1rw1r.sv
// Behavioural single-clock 1RW+1R SRAM with lane write masks, post-reset clear,
// registered reads with valid strobes and write-first forwarding onto port 1.
module sky130_sram_param_1rw1r
  import sram_param_pkg::*;
#(
  parameter int unsigned             DATA_WIDTH = 32,
  parameter int unsigned             ADDR_WIDTH = 8,
  parameter int unsigned             WRITE_SIZE = 8,
  parameter bit                      OUT_REG    = 1'b0,
  parameter bit                      INIT_EN    = 1'b1,
  parameter logic [DATA_WIDTH-1:0]   INIT_VALUE = '0,
  localparam int unsigned            NUM_WMASKS = num_wmasks(DATA_WIDTH, WRITE_SIZE)
) (
  input  logic                  clk,
  input  logic                  rstb,
  output logic                  init_done,
  input  logic                  csb0,
  input  logic                  web0,
  input  logic [NUM_WMASKS-1:0] wmask0,
  input  logic [ADDR_WIDTH-1:0] addr0,
  input  logic [DATA_WIDTH-1:0] din0,
  output logic [DATA_WIDTH-1:0] dout0,
  output logic                  dout0_vld,
  input  logic                  csb1,
  input  logic [ADDR_WIDTH-1:0] addr1,
  output logic [DATA_WIDTH-1:0] dout1,
  output logic                  dout1_vld,
  output logic                  coll1
);

  localparam int unsigned DEPTH = 1 << ADDR_WIDTH;

  if ((WRITE_SIZE == 0) || ((DATA_WIDTH % WRITE_SIZE) != 0)) begin : g_bad_write_size
    $error("DATA_WIDTH must be a non-zero multiple of WRITE_SIZE");
  end
  if (DATA_WIDTH > MAX_WIDTH) begin : g_bad_data_width
    $error("DATA_WIDTH exceeds the lane-merge helper width");
  end

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  logic                  clr_we;
  logic [ADDR_WIDTH-1:0] clr_addr;

  sram_clear_seq #(
    .ADDR_WIDTH (ADDR_WIDTH),
    .INIT_EN    (INIT_EN)
  ) u_clear_seq (
    .clk       (clk),
    .rstb      (rstb),
    .clr_we    (clr_we),
    .clr_addr  (clr_addr),
    .init_done (init_done)
  );

  logic                  rd0, wr0, rd1, coll;
  logic [DATA_WIDTH-1:0] wr_word, fwd_word;

  // Requests are only honoured once init_done is up and reset is released.
  always_comb begin
    rd0      = rstb && init_done && !csb0 && web0;
    wr0      = rstb && init_done && !csb0 && !web0;
    rd1      = rstb && init_done && !csb1;
    coll     = wr0 && rd1 && (addr0 == addr1);
    wr_word  = DATA_WIDTH'(lane_merge(MAX_WIDTH'(mem[addr0]), MAX_WIDTH'(din0),
                                      MAX_WIDTH'(wmask0), WRITE_SIZE));
    fwd_word = coll ? wr_word : mem[addr1];
  end

  always_ff @(posedge clk) begin
    if (rstb && clr_we) begin
      mem[clr_addr] <= INIT_VALUE;
    end else if (wr0) begin
      mem[addr0] <= wr_word;
    end
  end

  logic [DATA_WIDTH-1:0] rdata0, rdata1;
  logic                  rvld0, rvld1, rcoll1;

  always_ff @(posedge clk) begin
    if (!rstb) begin
      rdata0 <= '0;
      rdata1 <= '0;
      rvld0  <= 1'b0;
      rvld1  <= 1'b0;
      rcoll1 <= 1'b0;
    end else begin
      rvld0  <= rd0;
      rvld1  <= rd1;
      rcoll1 <= coll;
      if (rd0) rdata0 <= mem[addr0];
      if (rd1) rdata1 <= fwd_word;
    end
  end

  if (OUT_REG) begin : g_out_reg
    always_ff @(posedge clk) begin
      if (!rstb) begin
        dout0     <= '0;
        dout1     <= '0;
        dout0_vld <= 1'b0;
        dout1_vld <= 1'b0;
        coll1     <= 1'b0;
      end else begin
        dout0_vld <= rvld0;
        dout1_vld <= rvld1;
        coll1     <= rcoll1;
        if (rvld0) dout0 <= rdata0;
        if (rvld1) dout1 <= rdata1;
      end
    end
  end else begin : g_no_out_reg
    assign dout0     = rdata0;
    assign dout1     = rdata1;
    assign dout0_vld = rvld0;
    assign dout1_vld = rvld1;
    assign coll1     = rcoll1;
  end

endmodule

// File: tb/tb_sky130_sram_param_1rw1r.sv
// Directed bench: default instance via a vector table, plus a 64-bit OUT_REG
// instance and an INIT_EN=0 instance for latency, masking and init timing.
module tb_sky130_sram_param_1rw1r;

  logic clk = 1'b0;
  logic rstb;
  always #5 clk = ~clk;

  // Instance A: default parameters
  logic        done_a, csb0_a, web0_a, csb1_a;
  logic [3:0]  wmask0_a;
  logic [7:0]  addr0_a, addr1_a;
  logic [31:0] din0_a, dout0_a, dout1_a;
  logic        vld0_a, vld1_a, coll1_a;

  sky130_sram_param_1rw1r u_dut_a (
    .clk(clk), .rstb(rstb), .init_done(done_a),
    .csb0(csb0_a), .web0(web0_a), .wmask0(wmask0_a), .addr0(addr0_a), .din0(din0_a),
    .dout0(dout0_a), .dout0_vld(vld0_a),
    .csb1(csb1_a), .addr1(addr1_a), .dout1(dout1_a), .dout1_vld(vld1_a), .coll1(coll1_a)
  );

  // Instance B: 64-bit, 16-bit lanes, output register, small depth, non-zero init
  localparam logic [63:0] INIT_B = 64'h0123_4567_89AB_CDEF;
  logic        done_b, csb0_b, web0_b, csb1_b;
  logic [3:0]  wmask0_b, addr0_b, addr1_b;
  logic [63:0] din0_b, dout0_b, dout1_b;
  logic        vld0_b, vld1_b, coll1_b;

  sky130_sram_param_1rw1r #(
    .DATA_WIDTH(64), .ADDR_WIDTH(4), .WRITE_SIZE(16), .OUT_REG(1'b1),
    .INIT_EN(1'b1), .INIT_VALUE(INIT_B)
  ) u_dut_b (
    .clk(clk), .rstb(rstb), .init_done(done_b),
    .csb0(csb0_b), .web0(web0_b), .wmask0(wmask0_b), .addr0(addr0_b), .din0(din0_b),
    .dout0(dout0_b), .dout0_vld(vld0_b),
    .csb1(csb1_b), .addr1(addr1_b), .dout1(dout1_b), .dout1_vld(vld1_b), .coll1(coll1_b)
  );

  // Instance C: clear sweep disabled
  logic        done_c, vld0_c, vld1_c, coll1_c;
  logic [31:0] dout0_c, dout1_c;

  sky130_sram_param_1rw1r #(.ADDR_WIDTH(2), .INIT_EN(1'b0)) u_dut_c (
    .clk(clk), .rstb(rstb), .init_done(done_c),
    .csb0(1'b1), .web0(1'b1), .wmask0(4'h0), .addr0(2'd0), .din0(32'h0),
    .dout0(dout0_c), .dout0_vld(vld0_c),
    .csb1(1'b1), .addr1(2'd0), .dout1(dout1_c), .dout1_vld(vld1_c), .coll1(coll1_c)
  );

  int unsigned errors = 0;
  int unsigned checks = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    logic        csb0;
    logic        web0;
    logic [3:0]  wmask0;
    logic [7:0]  addr0;
    logic [31:0] din0;
    logic        csb1;
    logic [7:0]  addr1;
    logic [31:0] e_dout0;
    logic        e_vld0;
    logic [31:0] e_dout1;
    logic        e_vld1;
    logic        e_coll1;
  } vec_t;

  vec_t vecs[13];

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    int unsigned a_cycle, b_cycle, c_cycle, stray;

    //             csb0  web0  mask   a0     din0          csb1  a1     dout0         v0    dout1         v1    coll
    vecs[0]  = '{1'b0, 1'b1, 4'h0, 8'h00, 32'h0000_0000, 1'b0, 8'h80, 32'h0000_0000, 1'b1, 32'h0000_0000, 1'b1, 1'b0};
    vecs[1]  = '{1'b0, 1'b1, 4'h0, 8'hFF, 32'h0000_0000, 1'b1, 8'h00, 32'h0000_0000, 1'b1, 32'h0000_0000, 1'b0, 1'b0};
    vecs[2]  = '{1'b0, 1'b0, 4'h5, 8'h10, 32'hDEAD_BEEF, 1'b1, 8'h00, 32'h0000_0000, 1'b0, 32'h0000_0000, 1'b0, 1'b0};
    vecs[3]  = '{1'b0, 1'b1, 4'h0, 8'h10, 32'h0000_0000, 1'b0, 8'h10, 32'h00AD_00EF, 1'b1, 32'h00AD_00EF, 1'b1, 1'b0};
    vecs[4]  = '{1'b1, 1'b1, 4'h0, 8'h00, 32'h0000_0000, 1'b1, 8'h00, 32'h00AD_00EF, 1'b0, 32'h00AD_00EF, 1'b0, 1'b0};
    vecs[5]  = '{1'b0, 1'b0, 4'hF, 8'h05, 32'h1122_3344, 1'b0, 8'h05, 32'h00AD_00EF, 1'b0, 32'h1122_3344, 1'b1, 1'b1};
    vecs[6]  = '{1'b0, 1'b0, 4'h3, 8'h07, 32'hAABB_CCDD, 1'b0, 8'h06, 32'h00AD_00EF, 1'b0, 32'h0000_0000, 1'b1, 1'b0};
    vecs[7]  = '{1'b0, 1'b0, 4'h8, 8'h05, 32'h5566_7788, 1'b0, 8'h05, 32'h00AD_00EF, 1'b0, 32'h5522_3344, 1'b1, 1'b1};
    vecs[8]  = '{1'b0, 1'b1, 4'h0, 8'h05, 32'h0000_0000, 1'b0, 8'h07, 32'h5522_3344, 1'b1, 32'h0000_CCDD, 1'b1, 1'b0};
    vecs[9]  = '{1'b0, 1'b0, 4'h0, 8'h09, 32'hFFFF_FFFF, 1'b0, 8'h09, 32'h5522_3344, 1'b0, 32'h0000_0000, 1'b1, 1'b1};
    vecs[10] = '{1'b0, 1'b1, 4'h0, 8'h09, 32'h0000_0000, 1'b0, 8'hFF, 32'h0000_0000, 1'b1, 32'h0000_0000, 1'b1, 1'b0};
    vecs[11] = '{1'b0, 1'b1, 4'h0, 8'h10, 32'h0000_0000, 1'b1, 8'h00, 32'h00AD_00EF, 1'b1, 32'h0000_0000, 1'b0, 1'b0};
    vecs[12] = '{1'b1, 1'b0, 4'hF, 8'h10, 32'h0000_0000, 1'b0, 8'h10, 32'h00AD_00EF, 1'b0, 32'h00AD_00EF, 1'b1, 1'b0};

    rstb = 1'b0;
    csb0_a = 1'b1; web0_a = 1'b1; wmask0_a = '0; addr0_a = '0; din0_a = '0;
    csb1_a = 1'b1; addr1_a = '0;
    csb0_b = 1'b1; web0_b = 1'b1; wmask0_b = '0; addr0_b = '0; din0_b = '0;
    csb1_b = 1'b1; addr1_b = '0;

    tick; tick;
    check("rst_init_done_a", 64'(done_a), 64'h0);
    check("rst_dout0_a",     64'(dout0_a), 64'h0);
    check("rst_dout1_a",     64'(dout1_a), 64'h0);
    check("rst_vld_a",       64'({vld0_a, vld1_a, coll1_a}), 64'h0);
    check("rst_out_b",       64'({done_b, vld0_b, vld1_b, coll1_b}), 64'h0);
    check("rst_dout0_b",     dout0_b, 64'h0);

    // Release, run 100 clear cycles, then pulse reset mid-sweep.
    rstb = 1'b1;
    for (int i = 0; i < 100; i++) tick;
    check("mid_clear_init_done_a", 64'(done_a), 64'h0);
    check("b_done_before_reset",   64'(done_b), 64'h1);
    rstb = 1'b0;
    tick;
    check("reset_pulse_init_done_a", 64'(done_a), 64'h0);
    rstb = 1'b1;

    // Hammer port A with requests that must be ignored until init_done.
    csb0_a = 1'b0; web0_a = 1'b0; wmask0_a = 4'hF; addr0_a = 8'hFF; din0_a = 32'hFFFF_FFFF;
    csb1_a = 1'b0; addr1_a = 8'hFF;
    a_cycle = 0; b_cycle = 0; c_cycle = 0; stray = 0;
    for (int unsigned c = 1; c <= 400; c++) begin
      tick;
      if (vld0_a || vld1_a) stray++;
      if (b_cycle == 0 && done_b) b_cycle = c;
      if (c_cycle == 0 && done_c) c_cycle = c;
      if (done_a) begin
        a_cycle = c;
        break;
      end
      web0_a = c[0];
    end
    csb0_a = 1'b1; csb1_a = 1'b1; web0_a = 1'b1;
    check("init_done_rise_a", 64'(a_cycle), 64'd257);
    check("init_done_rise_b", 64'(b_cycle), 64'd17);
    check("init_done_rise_c", 64'(c_cycle), 64'd1);
    check("no_vld_during_init", 64'(stray), 64'd0);

    for (int i = 0; i < 13; i++) begin
      csb0_a = vecs[i].csb0; web0_a = vecs[i].web0; wmask0_a = vecs[i].wmask0;
      addr0_a = vecs[i].addr0; din0_a = vecs[i].din0;
      csb1_a = vecs[i].csb1; addr1_a = vecs[i].addr1;
      tick;
      check($sformatf("vec%0d_dout0", i), 64'(dout0_a), 64'(vecs[i].e_dout0));
      check($sformatf("vec%0d_vld0", i),  64'(vld0_a),  64'(vecs[i].e_vld0));
      check($sformatf("vec%0d_dout1", i), 64'(dout1_a), 64'(vecs[i].e_dout1));
      check($sformatf("vec%0d_vld1", i),  64'(vld1_a),  64'(vecs[i].e_vld1));
      check($sformatf("vec%0d_coll1", i), 64'(coll1_a), 64'(vecs[i].e_coll1));
    end
    csb0_a = 1'b1; csb1_a = 1'b1; web0_a = 1'b1;

    // B: two-cycle read latency, reading the init value.
    csb0_b = 1'b0; web0_b = 1'b1; addr0_b = 4'd3;
    tick;
    csb0_b = 1'b1;
    check("b_rd_lat1_vld0", 64'(vld0_b), 64'h0);
    tick;
    check("b_rd_lat2_vld0", 64'(vld0_b), 64'h1);
    check("b_rd_lat2_dout0", dout0_b, INIT_B);
    tick;
    check("b_rd_pulse_end", 64'(vld0_b), 64'h0);

    // B: mask 0b0010 writes bits [31:16] only.
    csb0_b = 1'b0; web0_b = 1'b0; wmask0_b = 4'b0010; addr0_b = 4'd3;
    din0_b = 64'h1111_2222_3333_4444;
    tick;
    csb0_b = 1'b1; web0_b = 1'b1; csb1_b = 1'b0; addr1_b = 4'd3;
    tick;
    csb1_b = 1'b1;
    tick;
    check("b_mask_dout1", dout1_b, 64'h0123_4567_3333_CDEF);
    check("b_mask_vld_coll", 64'({vld1_b, coll1_b}), 64'b10);

    // B: collision through the output register keeps coll1 aligned with vld.
    csb0_b = 1'b0; web0_b = 1'b0; wmask0_b = 4'b1001; addr0_b = 4'd4;
    din0_b = 64'hAAAA_BBBB_CCCC_DDDD; csb1_b = 1'b0; addr1_b = 4'd4;
    tick;
    csb0_b = 1'b1; web0_b = 1'b1; csb1_b = 1'b1;
    check("b_coll_lat1", 64'({vld1_b, coll1_b}), 64'b00);
    tick;
    check("b_coll_lat2", 64'({vld1_b, coll1_b}), 64'b11);
    check("b_coll_dout1", dout1_b, 64'hAAAA_4567_89AB_DDDD);
    tick;
    check("b_coll_pulse_end", 64'({vld1_b, coll1_b}), 64'b00);

    // In-flight reads are dropped by a reset.
    csb0_b = 1'b0; web0_b = 1'b1; addr0_b = 4'd3;
    csb0_a = 1'b0; web0_a = 1'b1; addr0_a = 8'h10;
    tick;
    csb0_b = 1'b1; csb0_a = 1'b1;
    check("a_read_before_reset", 64'({vld0_a, dout0_a}), {31'h0, 1'b1, 32'h00AD_00EF});
    rstb = 1'b0;
    tick;
    rstb = 1'b1;
    check("a_reset_clears_out", 64'({vld0_a, dout0_a}), 64'h0);
    tick;
    check("b_inflight_dropped_vld", 64'(vld0_b), 64'h0);
    check("b_inflight_dropped_dout", dout0_b, 64'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
